// File: rtl/fifo_push_arb_pkg.sv
// -----------------------------------------------------------------------------
// fifo_push_arb_pkg
// Shared definitions for the multi-requester FIFO push arbiter:
//   arb_state_e  - burst-lock FSM encoding (IDLE=0, LOCKED=1)
//   STALL_CNT_W  - width of the saturating stall counter
// -----------------------------------------------------------------------------
package fifo_push_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam int STALL_CNT_W = 16;

endpackage : fifo_push_arb_pkg

// File: rtl/fifo_push_arb_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational rotate-priority selector: returns a one-hot vector marking the
// first asserted request at or after ptr, searching upward modulo NREQ.
// Ports:
//   req  [NREQ-1:0]   - candidate requests
//   ptr  [PTR_W-1:0]  - highest-priority index (always < NREQ)
//   gnt  [NREQ-1:0]   - one-hot pick, all-zero when req is zero
// -----------------------------------------------------------------------------
module rr_pick #(
  parameter int NREQ  = 4,
  parameter int PTR_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt
);

  int   idx;
  logic found;

  // NOTE: every signal written here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      // Explicit wrap keeps non-power-of-2 NREQ correct.
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      // Compare against constant i so every index into req is a constant.
      for (int i = 0; i < NREQ; i++) begin
        if (!found && (idx == i) && req[i]) begin
          gnt[i] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

endmodule : rr_pick

// File: rtl/fifo_push_arb.sv
// -----------------------------------------------------------------------------
// fifo_push_arb
// Round-robin arbiter that lets NREQ producers share the push side of a single
// FIFO. Grant is combinational (zero latency) and nothing is buffered here.
//
// Optional feature macro: FIFO_ARB_BURST_LOCK_EN
//   When defined, a two-state FSM keeps the grant on one requester from its
//   first last=0 word until its last=1 word. When undefined, last is ignored
//   and every accepted word rotates the priority pointer.
//
// Ports:
//   clk        - clock, rising edge
//   reset_n    - asynchronous active-low reset
//   req        [NREQ-1:0]       - per-requester word valid
//   din        [NREQ*WIDTH-1:0] - requester i word at [i*WIDTH +: WIDTH]
//   last       [NREQ-1:0]       - per-requester end-of-burst marker
//   gnt        [NREQ-1:0]       - one-hot accept
//   fifo_push                   - push to the shared FIFO
//   fifo_din   [WIDTH-1:0]      - data to the shared FIFO
//   fifo_full                   - registered full flag from the FIFO
//   stall_cnt  [15:0]           - saturating count of stalled cycles
// -----------------------------------------------------------------------------
module fifo_push_arb
  import fifo_push_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*WIDTH-1:0]  din,
  input  logic [NREQ-1:0]        last,
  output logic [NREQ-1:0]        gnt,
  output logic                   fifo_push,
  output logic [WIDTH-1:0]       fifo_din,
  input  logic                   fifo_full,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam int PTR_W = $clog2(NREQ);

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] win_idx;
  logic [PTR_W-1:0] ptr_inc;
  logic [NREQ-1:0]  lock_mask;
  logic [NREQ-1:0]  pick;
  logic             accept;
  logic             ptr_advance;

  // ---------------------------------------------------------------------------
  // Burst lock
  // ---------------------------------------------------------------------------
`ifdef FIFO_ARB_BURST_LOCK_EN
  arb_state_e       state, state_nxt;
  logic [PTR_W-1:0] owner, owner_nxt;
  logic             win_last;

  assign win_last = |(last & gnt);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      owner <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    case (state)
      IDLE: begin
        if (accept && !win_last) begin
          state_nxt = LOCKED;
          owner_nxt = win_idx;
        end
      end
      LOCKED: begin
        // Only the owner can be granted while locked.
        if (accept && win_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    lock_mask = '1;
    if (state == LOCKED) begin
      for (int i = 0; i < NREQ; i++) lock_mask[i] = (owner == PTR_W'(i));
    end
    // Pointer moves only on accepts that leave the FSM idle; on burst exit
    // the winner is the owner, so ptr becomes owner+1.
    ptr_advance = accept && (state_nxt == IDLE);
  end
`else
  logic unused_last;

  assign unused_last = ^last;
  assign lock_mask   = '1;
  assign ptr_advance = accept;
`endif

  // ---------------------------------------------------------------------------
  // Grant path
  // ---------------------------------------------------------------------------
  rr_pick #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .req (req & lock_mask),
    .ptr (ptr),
    .gnt (pick)
  );

  // Reset gates the outputs combinationally so they are quiet while held.
  assign gnt       = (reset_n && !fifo_full) ? pick : '0;
  assign accept    = |gnt;
  assign fifo_push = accept;

  always_comb begin
    fifo_din = '0;
    win_idx  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        fifo_din = din[i*WIDTH +: WIDTH];
        win_idx  = PTR_W'(i);
      end
    end
  end

  assign ptr_inc = (win_idx == PTR_W'(NREQ - 1)) ? '0 : win_idx + PTR_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)         ptr <= '0;
    else if (ptr_advance) ptr <= ptr_inc;
  end

  // ---------------------------------------------------------------------------
  // Stall counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
    end else if ((|req) && fifo_full && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + STALL_CNT_W'(1);
    end
  end

endmodule : fifo_push_arb

// File: tb/tb_fifo_push_arb.sv
module tb_fifo_push_arb;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  req, last, gnt;
  logic [31:0] din;
  logic        fifo_full, fifo_push;
  logic [7:0]  fifo_din;
  logic [15:0] stall_cnt;

  logic [2:0]  req_b, last_b, gnt_b;
  logic [23:0] din_b;
  logic        full_b, push_b;
  logic [7:0]  fdin_b;
  logic [15:0] stall_b;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fifo_push_arb #(.NREQ(4), .WIDTH(8)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .din(din), .last(last),
    .gnt(gnt), .fifo_push(fifo_push), .fifo_din(fifo_din),
    .fifo_full(fifo_full), .stall_cnt(stall_cnt)
  );

  fifo_push_arb #(.NREQ(3), .WIDTH(8)) dut3 (
    .clk(clk), .reset_n(reset_n), .req(req_b), .din(din_b), .last(last_b),
    .gnt(gnt_b), .fifo_push(push_b), .fifo_din(fdin_b),
    .fifo_full(full_b), .stall_cnt(stall_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 reset_n = 1'b0;
    req = '0; last = '0; fifo_full = 1'b0;
    @(posedge clk);
    #2 reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req = 4'b1111; last = '0; fifo_full = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (gnt !== 4'b0000) begin miscompares++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
    vectors++;
    if (fifo_push !== 1'b0) begin miscompares++; $display("FAIL reset_push: got %b expected 0", fifo_push); end
    vectors++;
    if (fifo_din !== 8'h00) begin miscompares++; $display("FAIL reset_din: got %h expected 00", fifo_din); end
    vectors++;
    if (stall_cnt !== 16'h0000) begin miscompares++; $display("FAIL reset_stall: got %h expected 0000", stall_cnt); end
    req = '0; fifo_full = 1'b0;
    @(posedge clk);
    #2 reset_n = 1'b1;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [7:0] exp_d [5] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0};
    tick();
    req = 4'b1111; fifo_full = 1'b0;
    for (int s = 0; s < 5; s++) begin
      #1;
      vectors++;
      if (gnt !== exp_g[s] || fifo_din !== exp_d[s] || fifo_push !== 1'b1) begin
        miscompares++;
        $display("FAIL rr_step%0d: got gnt=%b din=%h push=%b expected gnt=%b din=%h push=1",
                 s, gnt, fifo_din, fifo_push, exp_g[s], exp_d[s]);
      end
      tick();
    end
    // ptr is now 1.
  endtask

  task automatic test_full_stall();
    req = 4'b0101; fifo_full = 1'b1;
    for (int s = 0; s < 5; s++) begin
      #1;
      vectors++;
      if (gnt !== 4'b0000 || fifo_push !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_step%0d: got gnt=%b push=%b expected gnt=0000 push=0", s, gnt, fifo_push);
      end
      tick();
    end
    vectors++;
    if (stall_cnt !== 16'd5) begin miscompares++; $display("FAIL stall_count: got %0d expected 5", stall_cnt); end
    // Full with no request must not count.
    req = 4'b0000;
    tick();
    vectors++;
    if (stall_cnt !== 16'd5) begin miscompares++; $display("FAIL stall_noreq: got %0d expected 5", stall_cnt); end
    // Release: ptr=1 so requester 2 wins, then ptr=3 wraps to requester 0.
    req = 4'b0101; fifo_full = 1'b0;
    #1;
    vectors++;
    if (gnt !== 4'b0100 || fifo_din !== 8'hA2) begin
      miscompares++; $display("FAIL stall_release: got gnt=%b din=%h expected gnt=0100 din=a2", gnt, fifo_din);
    end
    tick();
    vectors++;
    if (gnt !== 4'b0001 || fifo_din !== 8'hA0) begin
      miscompares++; $display("FAIL stall_wrap: got gnt=%b din=%h expected gnt=0001 din=a0", gnt, fifo_din);
    end
    req = 4'b0000;
    #1;
    vectors++;
    if (gnt !== 4'b0000 || fifo_push !== 1'b0 || fifo_din !== 8'h00) begin
      miscompares++; $display("FAIL idle_noreq: got gnt=%b push=%b din=%h expected 0000/0/00", gnt, fifo_push, fifo_din);
    end
  endtask

  task automatic test_burst();
`ifdef FIFO_ARB_BURST_LOCK_EN
    logic [3:0] exp_g [4] = '{4'b0001, 4'b0001, 4'b0001, 4'b0010};
`else
    logic [3:0] exp_g [4] = '{4'b0001, 4'b0010, 4'b0001, 4'b0010};
`endif
    logic [3:0] lst [4] = '{4'b0000, 4'b0000, 4'b0001, 4'b0000};
    do_reset();
    tick();
    req = 4'b0011; fifo_full = 1'b0;
    for (int s = 0; s < 4; s++) begin
      last = lst[s];
      #1;
      vectors++;
      if (gnt !== exp_g[s]) begin
        miscompares++; $display("FAIL burst_step%0d: got %b expected %b", s, gnt, exp_g[s]);
      end
      tick();
    end
    req = '0; last = '0;
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    tick();
    req = 4'b0100; last = 4'b0000; fifo_full = 1'b0;
    #1;
    vectors++;
    if (gnt !== 4'b0100) begin miscompares++; $display("FAIL midrst_start: got %b expected 0100", gnt); end
    tick();
    req = 4'b1100;
    #1;
    vectors++;
`ifdef FIFO_ARB_BURST_LOCK_EN
    if (gnt !== 4'b0100) begin miscompares++; $display("FAIL midrst_locked: got %b expected 0100", gnt); end
`else
    if (gnt !== 4'b1000) begin miscompares++; $display("FAIL midrst_locked: got %b expected 1000", gnt); end
`endif
    #1 reset_n = 1'b0;
    #1;
    vectors++;
    if (gnt !== 4'b0000 || fifo_push !== 1'b0 || fifo_din !== 8'h00) begin
      miscompares++; $display("FAIL midrst_assert: got gnt=%b push=%b din=%h expected 0000/0/00", gnt, fifo_push, fifo_din);
    end
    @(posedge clk);
    #2 reset_n = 1'b1;
    last = 4'b0100;
    #1;
    vectors++;
    if (gnt !== 4'b0100 || fifo_din !== 8'hA2) begin
      miscompares++; $display("FAIL midrst_release: got gnt=%b din=%h expected 0100/a2", gnt, fifo_din);
    end
    tick();
    vectors++;
    if (gnt !== 4'b1000 || fifo_din !== 8'hA3) begin
      miscompares++; $display("FAIL midrst_idle: got gnt=%b din=%h expected 1000/a3", gnt, fifo_din);
    end
    req = '0; last = '0;
  endtask

  task automatic test_saturation();
    do_reset();
    tick();
    req = 4'b0001; fifo_full = 1'b1;
    for (int n = 1; n <= 65600; n++) begin
      tick();
      if (n == 65534) begin
        vectors++;
        if (stall_cnt !== 16'hFFFE) begin miscompares++; $display("FAIL sat_pre: got %h expected fffe", stall_cnt); end
      end
      if (n == 65535) begin
        vectors++;
        if (stall_cnt !== 16'hFFFF) begin miscompares++; $display("FAIL sat_hit: got %h expected ffff", stall_cnt); end
      end
    end
    vectors++;
    if (stall_cnt !== 16'hFFFF || fifo_push !== 1'b0) begin
      miscompares++; $display("FAIL sat_hold: got cnt=%h push=%b expected ffff/0", stall_cnt, fifo_push);
    end
    req = '0; fifo_full = 1'b0;
  endtask

  task automatic test_npo2();
    logic [2:0] exp_g [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    logic [7:0] exp_d [6] = '{8'hB0, 8'hB1, 8'hB2, 8'hB0, 8'hB1, 8'hB2};
    do_reset();
    tick();
    req_b = 3'b111; full_b = 1'b0;
    for (int s = 0; s < 6; s++) begin
      #1;
      vectors++;
      if (gnt_b !== exp_g[s] || fdin_b !== exp_d[s] || push_b !== 1'b1) begin
        miscompares++;
        $display("FAIL npo2_step%0d: got gnt=%b din=%h push=%b expected gnt=%b din=%h push=1",
                 s, gnt_b, fdin_b, push_b, exp_g[s], exp_d[s]);
      end
      tick();
    end
    req_b = '0;
  endtask

  initial begin
    din = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    din_b = {8'hB2, 8'hB1, 8'hB0};
    req_b = '0; last_b = '0; full_b = 1'b0;
    test_reset();
    test_round_robin();
    test_full_stall();
    test_burst();
    test_reset_mid_burst();
    test_npo2();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_fifo_push_arb

// File: doc/fifo_push_arb.md
FIFO_PUSH_ARB -- requirements
Module: fifo_push_arb

Interface
REQ-001 The block SHALL have parameter NREQ, default 4: number of requesters, range 2..8.
REQ-002 The block SHALL have parameter WIDTH, default 8: data word width, matching the shared FIFO width.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port req, input, NREQ bits: per-requester word valid.
REQ-006 The block SHALL have port din, input, NREQ*WIDTH bits: requester i word in bits [i*WIDTH +: WIDTH].
REQ-007 The block SHALL have port last, input, NREQ bits: per-requester end-of-burst marker, qualified by req.
REQ-008 The block SHALL have port gnt, output, NREQ bits: one-hot accept; the word transfers when req[i] and gnt[i] are both high at a clock edge.
REQ-009 The block SHALL have port fifo_push, output, 1 bit: drives the shared FIFO push input.
REQ-010 The block SHALL have port fifo_din, output, WIDTH bits: drives the shared FIFO Din input.
REQ-011 The block SHALL have port fifo_full, input, 1 bit: registered full flag from the shared FIFO.
REQ-012 The block SHALL have port stall_cnt, output, 16 bits: saturating count of stalled cycles.

Function
REQ-013 The grant SHALL be combinational from req, fifo_full, the priority pointer and the lock state; zero-cycle latency from req to gnt.
REQ-014 gnt SHALL be all-zero whenever fifo_full=1 or req=0.
REQ-015 Otherwise gnt SHALL select the first asserted req at or after the priority pointer ptr, searching upward modulo NREQ.
REQ-016 At most one gnt bit SHALL be high in any cycle.
REQ-017 fifo_push SHALL equal the OR-reduction of gnt; fifo_din SHALL equal the granted requester's word, or 0 when no grant is given.
REQ-018 On a clock edge with an accepted word from requester w, ptr SHALL become (w+1) mod NREQ, except while locked (REQ-026).
REQ-019 ptr SHALL hold when no word is accepted.
REQ-020 The pointer SHALL be ceil(log2(NREQ)) bits wide; for non-power-of-2 NREQ, wrap SHALL be explicit at NREQ-1 -> 0.
REQ-021 stall_cnt SHALL increment by 1 on each edge where req!=0 and fifo_full=1, and SHALL saturate at 16'hFFFF.
REQ-022 Requesters SHALL hold req and data stable until granted; the block SHALL NOT buffer any data.
REQ-023 A requester deasserting req before grant SHALL simply drop out of arbitration, with no state change.

Reset
REQ-024 While reset_n=0: ptr=0, state=IDLE, owner=0, stall_cnt=0; gnt, fifo_push and fifo_din SHALL be 0 regardless of req.
REQ-025 Reset asserted mid-burst SHALL abandon the lock immediately; after release, arbitration SHALL restart from requester 0.

Configuration
REQ-026 With FIFO_ARB_BURST_LOCK_EN defined, a two-state FSM SHALL be compiled in:
- IDLE -> LOCKED(owner=w) on an accepted word with last=0.
- LOCKED -> IDLE on an accepted owner word with last=1; ptr then becomes (owner+1) mod NREQ.
- While LOCKED, only the owner may be granted; other requests wait even when the owner's req=0; ptr holds.
- An accepted word with last=1 in IDLE SHALL leave the state IDLE.
REQ-027 Without FIFO_ARB_BURST_LOCK_EN, the last input SHALL be ignored, no FSM SHALL exist, and every accept SHALL rotate ptr.

Structure
REQ-028 A shared package SHALL hold the FSM state encoding (IDLE=0, LOCKED=1) and the stall-counter width constant (16).
REQ-029 A sub-module rr_pick SHALL contain the combinational rotate-priority one-hot selector (inputs req and ptr; output one-hot); fifo_push_arb SHALL instantiate it once.

Verification
REQ-030 Round-robin fairness: NREQ=4, req=4'b1111 held, fifo_full=0 -> gnt sequence 0001,0010,0100,1000,0001; fifo_din tracks each requester's word.
REQ-031 Full stall: req=4'b0101, fifo_full=1 for 5 cycles -> gnt=0, fifo_push=0, stall_cnt=5. After fifo_full=0, gnt=0001 or 0100 according to ptr.
REQ-032 Burst lock (macro on): req0 sends 3 words with last=0,0,1 while req=4'b0011 -> gnt=0001 for 3 accepts, then 0010. With the macro off -> 0001,0010,0001 alternation.
REQ-033 Reset mid-burst: assert reset_n=0 while LOCKED on requester 2 -> gnt=0 immediately. After release with req=4'b1100, first gnt=0100 and state=IDLE.
REQ-034 Saturation: force 70000 stalled cycles -> stall_cnt holds 16'hFFFF with no wrap.
REQ-035 Non-power-of-2: NREQ=3, req=3'b111 -> gnt rotates 001,010,100,001; ptr never reaches 3.
